systolic_data_setup: RTL and testbench
======================================

Name: systolic_data_setup

Overview:
- Upstream feeder for the weight-stationary Matrix Multiply Unit. It takes one LENGTH-lane activation vector per handshake and emits the diagonally skewed wavefront the systolic array needs: lane i is delayed by i extra advances.
- Drives the array's EN through Out_Valid.
- After the last vector of a tile it drains LENGTH-1 zero-filled advances, so every lane flushes completely.

Parameters:
- WIDTH, 8, bits per element.
- LENGTH, 256, lanes, which equals the array dimension; also the maximum vectors per tile.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- ASYNC_RST  input  1  asynchronous, active-low reset.
- In_Valid  input  1  upstream vector valid.
- In_Ready  output  1  block can accept a vector this cycle.
- In_Last  input  1  accepted vector is the last of its tile.
- Inputs  input  WIDTH*LENGTH  lane i at bits [WIDTH*LENGTH-1-i*WIDTH -: WIDTH]; lane 0 is the MSB slice.
- Out_Ready  input  1  downstream (array) can advance this cycle.
- Skewed  output  WIDTH*LENGTH  skewed lanes, same packing as Inputs; drives the array's Inputs.
- Out_Valid  output  1  Skewed updated this cycle; connects to array EN.
- Out_Last  output  1  final drain beat of the tile.
- Busy  output  1  state is not IDLE.

Behaviour:
- Reset (ASYNC_RST=0, any time, including mid-tile): all delay registers 0, state IDLE, counters 0. Outputs go to Skewed=0, Out_Valid=0, Out_Last=0, Busy=0. In_Ready follows its equation, so it is Out_Ready.
- States:
  - IDLE: no tile in progress.
  - STREAM: tile in progress, accepting vectors.
  - DRAIN: shifting zeros in to flush the lanes.
- In_Ready = Out_Ready and (state is IDLE or STREAM). It is combinational and never depends on In_Valid.
- accept = In_Valid and In_Ready.
- advance = accept, or (state DRAIN and Out_Ready). An advance is the only event that shifts the delay lines.
- Delay lines:
  - Lane i is a shift register of depth i+1.
  - On an accept advance, lane i's head loads Inputs lane i. On a drain advance, the head loads 0.
  - The Skewed lane i output is the tail register of lane i.
  - Without an advance, all registers hold. A stall freezes the wavefront intact.
- Latency: the element of lane i from the k-th accepted vector (k from 0) appears on Skewed at the clock edge closing the (k+i+1)-th advance of the tile.
- Out_Valid is a register equal to advance on the previous cycle. It is high exactly one cycle per advance and is never high with unchanged data.
- Vector counter vec_cnt, width $clog2(LENGTH)+1:
  - Increments on accept and clears on tile end.
  - The effective last flag is eff_last = In_Last or (vec_cnt == LENGTH-1). The LENGTH-th vector is forced last, so a tile never exceeds LENGTH vectors.
- Transitions:
  - IDLE: on accept with eff_last=0, go to STREAM.
  - IDLE or STREAM: on accept with eff_last=1, go to DRAIN and load drain_cnt = LENGTH-1.
  - LENGTH==1 special case: go to IDLE instead of DRAIN, and assert Out_Last with that beat.
  - DRAIN: on each drain advance, decrement drain_cnt. The advance taken with drain_cnt==1 sets Out_Last=1 for the next cycle, and the state goes to IDLE.
  - No accepts occur during DRAIN, because In_Ready=0.
- Out_Last is a register that pulses one cycle, coincident with the Out_Valid of the final drain beat.
- A new tile may be accepted in the cycle immediately after the IDLE return. There are no bubbles between tiles except drain.
- Busy is high in STREAM or DRAIN.
- In_Valid deasserted in STREAM: no advance, outputs hold, state stays STREAM.
- Out_Ready low: no accept and no drain step. In_Last is ignored unless accepted.

Test Plan:
- LENGTH=4, WIDTH=8, one vector {1,2,3,4} with In_Last, Out_Ready=1 continuously:
  - Out_Valid is high 4 consecutive cycles.
  - Skewed beats are {1,0,0,0}, {0,2,0,0}, {0,0,3,0}, {0,0,0,4}.
  - Out_Last is high on beat 4 only; Busy then falls.
- Two vectors, {1,2,3,4} then {5,6,7,8} (last):
  - Beats: {1,0,0,0}, {5,2,0,0}, {0,6,3,0}, {0,0,7,4}, {0,0,0,8}.
  - Out_Last is on beat 5.
- Same stream as the two-vector case, with Out_Ready=0 for 3 cycles after beat 2:
  - In_Ready and Out_Valid are 0 during the stall and Skewed holds {5,2,0,0].
  - The remaining beats are identical and Out_Last stays on the final beat.
- Five vectors 1..5 with In_Last never asserted:
  - The 4th accept is forced last; In_Ready is 0 for the 3 drain cycles.
  - Vector 5 is accepted in the cycle after the state returns to IDLE, as a new tile.
- ASYNC_RST pulsed low during DRAIN: Skewed=0, Out_Valid=0, Busy=0 immediately. After release, In_Ready=Out_Ready, and a fresh single-vector tile behaves as in the first scenario.
- LENGTH=1, vector {9} with In_Last: one beat, Skewed={9}, with Out_Valid and Out_Last both high on the same cycle, then the state returns to IDLE with no drain.

Source files
------------

// File: rtl/systolic_data_setup.sv
// systolic_data_setup: turns one LENGTH-lane activation vector per handshake
// into the diagonally skewed wavefront for a weight-stationary systolic array.
// Lane i sees i extra advances of delay. After the last vector of a tile,
// LENGTH-1 zero advances flush every lane before the next tile can start.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no tile in progress
// STREAM | tile in progress, accepting vectors
// DRAIN  | shifting zeros in to flush the delay lines
module systolic_data_setup #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 256
) (
  input  logic                    CLK,
  input  logic                    ASYNC_RST,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic                    In_Last,
  input  logic [WIDTH*LENGTH-1:0] Inputs,
  input  logic                    Out_Ready,
  output logic [WIDTH*LENGTH-1:0] Skewed,
  output logic                    Out_Valid,
  output logic                    Out_Last,
  output logic                    Busy
);

  localparam int CNT_W  = $clog2(LENGTH) + 1;
  localparam bit SINGLE = (LENGTH == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] drain_cnt;

  logic accept;
  logic drain_adv;
  logic advance;
  logic eff_last;
  logic last_beat;
  logic tile_end;

  // Handshake and advance qualifiers; In_Ready never looks at In_Valid.
  always_comb begin
    In_Ready  = Out_Ready && ((state == IDLE) || (state == STREAM));
    accept    = In_Valid && In_Ready;
    drain_adv = (state == DRAIN) && Out_Ready;
    advance   = accept || drain_adv;
    // The LENGTH-th vector is forced last so a tile never overruns the array.
    eff_last  = In_Last || (vec_cnt == CNT_W'(LENGTH - 1));
    tile_end  = accept && eff_last;
    // With a single lane there is nothing to drain, so the accept beat is final.
    last_beat = (drain_adv && (drain_cnt == CNT_W'(1))) || (SINGLE && tile_end);
  end

  // State register.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!eff_last)   state_nxt = STREAM;
          else if (SINGLE) state_nxt = IDLE;
          else             state_nxt = DRAIN;
        end
      end
      STREAM: begin
        if (tile_end) state_nxt = SINGLE ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (drain_adv && (drain_cnt == CNT_W'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector count within the tile; cleared when the tile's last vector is taken.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      vec_cnt <= '0;
    end else if (accept) begin
      vec_cnt <= eff_last ? '0 : vec_cnt + CNT_W'(1);
    end
  end

  // Drain down-counter; terminal count 1 marks the final flush beat.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      drain_cnt <= '0;
    end else if (tile_end && !SINGLE) begin
      drain_cnt <= CNT_W'(LENGTH - 1);
    end else if (drain_adv) begin
      drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  // Output strobes: one Out_Valid per advance, Out_Last on the tile's final beat.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      Out_Valid <= 1'b0;
      Out_Last  <= 1'b0;
    end else begin
      Out_Valid <= advance;
      Out_Last  <= last_beat;
    end
  end

  assign Busy = (state == STREAM) || (state == DRAIN);

  // Triangular delay network: lane g is a shift register of depth g+1.
  for (genvar g = 0; g < LENGTH; g++) begin : g_lane
    logic [WIDTH-1:0] lane_in;
    logic [WIDTH-1:0] line [0:g];

    // Drain advances push zeros so the tail of the wavefront flushes cleanly.
    assign lane_in = accept ? Inputs[WIDTH*LENGTH-1-g*WIDTH -: WIDTH] : '0;

    // Shift only on an advance; a stall freezes the whole wavefront.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        for (int j = 0; j <= g; j++) line[j] <= '0;
      end else if (advance) begin
        line[0] <= lane_in;
        for (int j = 1; j <= g; j++) line[j] <= line[j-1];
      end
    end

    assign Skewed[WIDTH*LENGTH-1-g*WIDTH -: WIDTH] = line[g];
  end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Directed bench for systolic_data_setup: a 4-lane instance for the main
// scenarios and a 1-lane instance for the no-drain corner.
module tb_systolic_data_setup;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_last, out_ready;
  logic [31:0] inputs;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] skewed;

  logic        in_valid1, in_last1, out_ready1;
  logic [7:0]  inputs1;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [7:0]  skewed1;

  int n_checks = 0;
  int n_errors = 0;

  systolic_data_setup #(.WIDTH(8), .LENGTH(4)) u_dut4 (
    .CLK       (clk),
    .ASYNC_RST (rst_n),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_Last   (in_last),
    .Inputs    (inputs),
    .Out_Ready (out_ready),
    .Skewed    (skewed),
    .Out_Valid (out_valid),
    .Out_Last  (out_last),
    .Busy      (busy)
  );

  systolic_data_setup #(.WIDTH(8), .LENGTH(1)) u_dut1 (
    .CLK       (clk),
    .ASYNC_RST (rst_n),
    .In_Valid  (in_valid1),
    .In_Ready  (in_ready1),
    .In_Last   (in_last1),
    .Inputs    (inputs1),
    .Out_Ready (out_ready1),
    .Skewed    (skewed1),
    .Out_Valid (out_valid1),
    .Out_Last  (out_last1),
    .Busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One clock on the 4-lane instance: drive, check In_Ready before the edge,
  // then check the registered outputs just after it.
  task automatic cyc(input string tag, input logic v, input logic lst,
                     input logic [31:0] vec, input logic ordy, input logic exp_irdy,
                     input logic [31:0] exp_sk, input logic exp_ov,
                     input logic exp_ol, input logic exp_busy);
    in_valid  = v;
    in_last   = lst;
    inputs    = vec;
    out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_irdy));
    @(posedge clk);
    #1;
    check({tag, ".skewed"},    skewed,           exp_sk);
    check({tag, ".out_valid"}, 32'(out_valid),   32'(exp_ov));
    check({tag, ".out_last"},  32'(out_last),    32'(exp_ol));
    check({tag, ".busy"},      32'(busy),        32'(exp_busy));
  endtask

  task automatic single_tile(input string tag);
    cyc({tag, ".b1"}, 1, 1, 32'h01020304, 1, 1, 32'h01000000, 1, 0, 1);
    cyc({tag, ".b2"}, 0, 0, 32'h0,        1, 0, 32'h00020000, 1, 0, 1);
    cyc({tag, ".b3"}, 0, 0, 32'h0,        1, 0, 32'h00000300, 1, 0, 1);
    cyc({tag, ".b4"}, 0, 0, 32'h0,        1, 0, 32'h00000004, 1, 1, 0);
    cyc({tag, ".idle"}, 0, 0, 32'h0,      1, 1, 32'h00000004, 0, 0, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    inputs     = '0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_last1   = 1'b0;
    inputs1    = '0;
    out_ready1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst.skewed",    skewed,          32'h0);
    check("rst.out_valid", 32'(out_valid),  32'h0);
    check("rst.out_last",  32'(out_last),   32'h0);
    check("rst.busy",      32'(busy),       32'h0);
    check("rst.in_ready1", 32'(in_ready),   32'h1);
    out_ready = 1'b0;
    #1;
    check("rst.in_ready0", 32'(in_ready),   32'h0);
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;

    // Single vector tile.
    single_tile("one");

    // Two-vector tile.
    cyc("two.b1", 1, 0, 32'h01020304, 1, 1, 32'h01000000, 1, 0, 1);
    cyc("two.b2", 1, 1, 32'h05060708, 1, 1, 32'h05020000, 1, 0, 1);
    cyc("two.b3", 0, 0, 32'h0,        1, 0, 32'h00060300, 1, 0, 1);
    cyc("two.b4", 0, 0, 32'h0,        1, 0, 32'h00000704, 1, 0, 1);
    cyc("two.b5", 0, 0, 32'h0,        1, 0, 32'h00000008, 1, 1, 0);
    cyc("two.idle", 0, 0, 32'h0,      1, 1, 32'h00000008, 0, 0, 0);

    // Two-vector tile with a STREAM bubble (In_Last ignored) and a DRAIN stall.
    cyc("stl.b1",  1, 0, 32'h01020304, 1, 1, 32'h01000000, 1, 0, 1);
    cyc("stl.gap", 0, 1, 32'hdeadbeef, 1, 1, 32'h01000000, 0, 0, 1);
    cyc("stl.b2",  1, 1, 32'h05060708, 1, 1, 32'h05020000, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("stl.hold", 0, 0, 32'h0, 0, 0, 32'h05020000, 0, 0, 1);
    cyc("stl.b3", 0, 0, 32'h0, 1, 0, 32'h00060300, 1, 0, 1);
    cyc("stl.b4", 0, 0, 32'h0, 1, 0, 32'h00000704, 1, 0, 1);
    cyc("stl.b5", 0, 0, 32'h0, 1, 0, 32'h00000008, 1, 1, 0);
    cyc("stl.idle", 0, 0, 32'h0, 1, 1, 32'h00000008, 0, 0, 0);

    // Four vectors without In_Last: the 4th is forced last; the 5th starts a new tile.
    cyc("frc.a1", 1, 0, 32'h11121314, 1, 1, 32'h11000000, 1, 0, 1);
    cyc("frc.a2", 1, 0, 32'h21222324, 1, 1, 32'h21120000, 1, 0, 1);
    cyc("frc.a3", 1, 0, 32'h31323334, 1, 1, 32'h31221300, 1, 0, 1);
    cyc("frc.a4", 1, 0, 32'h41424344, 1, 1, 32'h41322314, 1, 0, 1);
    cyc("frc.d1", 1, 0, 32'h51525354, 1, 0, 32'h00423324, 1, 0, 1);
    cyc("frc.d2", 1, 0, 32'h51525354, 1, 0, 32'h00004334, 1, 0, 1);
    cyc("frc.d3", 1, 0, 32'h51525354, 1, 0, 32'h00000044, 1, 1, 0);
    cyc("frc.a5", 1, 0, 32'h51525354, 1, 1, 32'h51000000, 1, 0, 1);
    cyc("frc.a6", 1, 1, 32'h61626364, 1, 1, 32'h61520000, 1, 0, 1);
    cyc("frc.e1", 0, 0, 32'h0,        1, 0, 32'h00625300, 1, 0, 1);
    cyc("frc.e2", 0, 0, 32'h0,        1, 0, 32'h00006354, 1, 0, 1);
    cyc("frc.e3", 0, 0, 32'h0,        1, 0, 32'h00000064, 1, 1, 0);

    // Asynchronous reset in the middle of DRAIN.
    cyc("ard.b1", 1, 1, 32'h0a0b0c0d, 1, 1, 32'h0a000000, 1, 0, 1);
    cyc("ard.b2", 0, 0, 32'h0,        1, 0, 32'h000b0000, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    check("ard.skewed",    skewed,         32'h0);
    check("ard.out_valid", 32'(out_valid), 32'h0);
    check("ard.out_last",  32'(out_last),  32'h0);
    check("ard.busy",      32'(busy),      32'h0);
    check("ard.in_ready",  32'(in_ready),  32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    single_tile("post");

    // Single-lane instance: accept beat is also the final beat, no drain.
    in_valid1 = 1'b1;
    in_last1  = 1'b1;
    inputs1   = 8'd9;
    #1;
    check("l1.in_ready", 32'(in_ready1), 32'h1);
    @(posedge clk);
    #1;
    check("l1.skewed",    32'(skewed1),    32'd9);
    check("l1.out_valid", 32'(out_valid1), 32'h1);
    check("l1.out_last",  32'(out_last1),  32'h1);
    check("l1.busy",      32'(busy1),      32'h0);
    in_valid1 = 1'b0;
    in_last1  = 1'b0;
    @(posedge clk);
    #1;
    check("l1.idle.skewed",    32'(skewed1),    32'd9);
    check("l1.idle.out_valid", 32'(out_valid1), 32'h0);
    check("l1.idle.out_last",  32'(out_last1),  32'h0);
    check("l1.idle.in_ready",  32'(in_ready1),  32'h1);
    in_valid1 = 1'b1;
    inputs1   = 8'd7;
    @(posedge clk);
    #1;
    check("l1.frc.skewed",   32'(skewed1),   32'd7);
    check("l1.frc.out_last", 32'(out_last1), 32'h1);
    check("l1.frc.busy",     32'(busy1),     32'h0);
    in_valid1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
